multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the project's MIPS-subset datapath: ADD, SUB, AND, OR, SLT, ADDI, LW, SW, SLTI, BEQ.
- It shares one memory port between instruction fetch and load/store through a req/ready handshake.
- It drives PC, IR, ALU, register-file and memory control, and counts retired and skipped instructions.
- It sits between the datapath (PC, IR, register file, ALU) and the memory port.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps)
FAULT_W, 16, width of fault counter (saturates)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-high
run_i  in  1  1 = keep issuing instructions; sampled only at instruction boundaries
instr_i  in  32  current IR contents, from datapath
mem_ready_i  in  1  memory completes the current request this cycle
alu_zero_i  in  1  ALU result == 0 (valid in EXEC)
addr_misalign_i  in  1  ALU address bits[1:0] != 0 (valid in EXEC)
mem_req_o  out  1  memory request
mem_we_o  out  1  write (SW only)
mem_sel_o  out  1  0 = instruction fetch, 1 = data
ir_write_o  out  1  latch memory read data into IR
pc_write_o  out  1  update PC
pc_src_o  out  1  0 = PC+4, 1 = PC+4+(sext(imm)<<2)
alu_op_o  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
alu_src_b_o  out  1  0 = rt register, 1 = sext(imm)
reg_write_o  out  1  register-file write enable
reg_dst_o  out  1  0 = rt, 1 = rd
mem_to_reg_o  out  1  writeback from memory data
retire_o  out  1  one-cycle pulse when an instruction completes or is skipped
state_o  out  3  current FSM state
instr_cnt_o  out  CNT_W  retired-instruction count
fault_cnt_o  out  FAULT_W  illegal plus misaligned instruction count

Behaviour:
Register and output structure:
- Registered: state, instr_cnt_o, fault_cnt_o.
- All other outputs are combinational functions of state and instr_i.
- Outputs default to 0 whenever not asserted below.
Reset:
- rst_i=1 immediately forces state IDLE and both counters to 0, so every output reads 0.
- Reset mid-instruction drops mem_req_o at once (asynchronously); the in-flight instruction is abandoned and not retired.
States (state_o encoding):
- IDLE(0): if run_i=1 go to FETCH.
- FETCH(1): mem_req_o=1, mem_sel_o=0. Hold until mem_ready_i=1; in that cycle ir_write_o=1, then go to DECODE.
- DECODE(2): classify instr_i.
  - Legal opcode (R-type with a listed func, ADDI, SLTI, LW, SW, BEQ): go to EXEC.
  - Anything else: skip.
- EXEC(3): alu_src_b_o=1 for ADDI, SLTI, LW, SW.
  - alu_op_o: from func for R-type; ADD for ADDI/LW/SW; SLT for SLTI; SUB for BEQ.
  - R/ADDI/SLTI: go to WB.
  - LW/SW with addr_misalign_i=1: skip. Otherwise go to MEM.
  - BEQ: pc_write_o=1, pc_src_o=alu_zero_i, retire_o=1, go to NEXT.
- MEM(4): mem_req_o=1, mem_sel_o=1, mem_we_o=(SW). Hold until mem_ready_i.
  - SW on ready: pc_write_o=1, pc_src_o=0, retire_o=1, go to NEXT.
  - LW on ready: go to WB.
- WB(5): reg_write_o=1 unless destination==0.
  - Destination is rd for R-type (reg_dst_o=1), rt otherwise.
  - mem_to_reg_o=1 for LW.
  - pc_write_o=1, pc_src_o=0, retire_o=1, go to NEXT.
Skip:
- pc_write_o=1, pc_src_o=0, retire_o=1.
- fault_cnt_o increments, saturating at all-ones.
- Go to NEXT.
NEXT:
- run_i=1 goes to FETCH; run_i=0 goes to IDLE.
- Dropping run_i mid-instruction always completes that instruction first.
Counters:
- instr_cnt_o += 1 on every retire_o pulse, skips included; wraps modulo 2^CNT_W.
- When a saturating fault and a retire occur in the same cycle, both counters update.
Handshake:
- Once raised, mem_req_o, mem_we_o and mem_sel_o stay stable until the mem_ready_i cycle.
- mem_ready_i outside FETCH/MEM is ignored.
Latency with mem_ready_i tied high (cycles FETCH to retire inclusive):
- R-type/ADDI/SLTI: 4
- LW: 5
- SW: 4
- BEQ: 3
- Illegal: 2
- Misaligned LW/SW: 3
- Each memory wait cycle adds 1.
Scope split:
- PC range clamping and register-0 hardwiring are the datapath's job.
- The controller never writes destination 0.

Decomposition:
- Package sim_ctrl_pkg holds:
  - opcode constants (0x00, 0x08, 0x23, 0x2b, 0x0a, 0x04)
  - func constants (0x20, 0x22, 0x24, 0x25, 0x2a)
  - alu_op encodings
  - state enum
- One combinational sub-module, instr_class_dec: instr_i in; is_rtype, is_imm_alu, is_lw, is_sw, is_beq, is_legal, dest_is_zero out.

Test Plan:
1. Reset: mem_ready_i=1, run_i=1; assert rst_i during FETCH -> mem_req_o=0 same cycle; state_o=0, instr_cnt_o=0 after release; FETCH on the first clock with run_i=1.
2. ADD r3,r1,r2 (0x00221820), mem_ready_i=1 -> states 1,2,3,5; in WB reg_write_o=1, reg_dst_o=1, alu_op_o=0; retire on cycle 4; instr_cnt_o=1.
3. LW r5,8(r0) (0x8C050008), mem_ready_i delayed 3 cycles in MEM -> mem_req_o=1, mem_sel_o=1, mem_we_o=0 held 4 cycles; then WB with mem_to_reg_o=1; retire on cycle 8.
4. BEQ r1,r1,-2 (0x1021FFFE), alu_zero_i=1 -> EXEC pc_write_o=1, pc_src_o=1, retire; with alu_zero_i=0 -> pc_src_o=0; no WB or MEM state entered.
5. SW with addr_misalign_i=1 -> MEM never entered, mem_req_o stays 0 after FETCH, fault_cnt_o=1, instr_cnt_o=1. Opcode 0x3F -> skip from DECODE, fault_cnt_o=2.
6. ADDI r0,r0,5 -> reg_write_o=0 in WB. run_i dropped during EXEC -> instruction retires, then state_o=0, no further mem_req_o.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller.
// Opcodes, R-type function codes, ALU op codes and FSM states.
package sim_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  function automatic logic [2:0] func_to_aluop(input logic [5:0] func);
    case (func)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Combinational instruction classifier: splits the IR into the classes the FSM branches on.
module instr_class_dec
  import sim_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        is_rtype,
  output logic        is_imm_alu,
  output logic        is_lw,
  output logic        is_sw,
  output logic        is_beq,
  output logic        is_legal,
  output logic        dest_is_zero
);

  logic [5:0] w_op;
  logic [5:0] w_func;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_unused_bits;

  assign w_op   = instr_i[31:26];
  assign w_rt   = instr_i[20:16];
  assign w_rd   = instr_i[15:11];
  assign w_func = instr_i[5:0];
  assign w_unused_bits = ^{instr_i[25:21], instr_i[10:6]};

  assign is_rtype = (w_op == OP_RTYPE) &&
                    (w_func == FN_ADD || w_func == FN_SUB || w_func == FN_AND ||
                     w_func == FN_OR  || w_func == FN_SLT);
  assign is_imm_alu   = (w_op == OP_ADDI) || (w_op == OP_SLTI);
  assign is_lw        = (w_op == OP_LW);
  assign is_sw        = (w_op == OP_SW);
  assign is_beq       = (w_op == OP_BEQ);
  assign is_legal     = is_rtype | is_imm_alu | is_lw | is_sw | is_beq;
  // R-type writes rd; every other writer targets rt.
  assign dest_is_zero = is_rtype ? (w_rd == 5'd0) : (w_rt == 5'd0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath; one shared memory port via req/ready.
// Only state and the two counters are registered; all other outputs decode state and IR.
module multicycle_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int FAULT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               run_i,
  input  logic [31:0]        instr_i,
  input  logic               mem_ready_i,
  input  logic               alu_zero_i,
  input  logic               addr_misalign_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic               mem_sel_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic               pc_src_o,
  output logic [2:0]         alu_op_o,
  output logic               alu_src_b_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               retire_o,
  output logic [2:0]         state_o,
  output logic [CNT_W-1:0]   instr_cnt_o,
  output logic [FAULT_W-1:0] fault_cnt_o
);

  state_t r_state;
  state_t w_next;
  logic   w_fault;
  logic   w_rtype, w_imm_alu, w_lw, w_sw, w_beq, w_legal, w_dest_zero;

  instr_class_dec u_dec (
    .instr_i      (instr_i),
    .is_rtype     (w_rtype),
    .is_imm_alu   (w_imm_alu),
    .is_lw        (w_lw),
    .is_sw        (w_sw),
    .is_beq       (w_beq),
    .is_legal     (w_legal),
    .dest_is_zero (w_dest_zero)
  );

  always_comb begin
    w_next       = r_state;
    w_fault      = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_sel_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    alu_op_o     = ALU_ADD;
    alu_src_b_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    retire_o     = 1'b0;
    case (r_state)
      ST_IDLE: if (run_i) w_next = ST_FETCH;
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          w_next     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_legal) w_next = ST_EXEC;
        else         w_fault = 1'b1;
      end
      ST_EXEC: begin
        alu_src_b_o = w_imm_alu | w_lw | w_sw;
        if (w_rtype)                     alu_op_o = func_to_aluop(instr_i[5:0]);
        else if (w_beq)                  alu_op_o = ALU_SUB;
        else if (instr_i[31:26] == OP_SLTI) alu_op_o = ALU_SLT;
        if (w_rtype || w_imm_alu)        w_next = ST_WB;
        else if ((w_lw || w_sw) && !addr_misalign_i) w_next = ST_MEM;
        else if (w_beq) begin
          pc_src_o = alu_zero_i;
          retire_o = 1'b1;
        end else                         w_fault = 1'b1;
      end
      ST_MEM: begin
        mem_req_o = 1'b1;
        mem_sel_o = 1'b1;
        mem_we_o  = w_sw;
        if (mem_ready_i) begin
          if (w_sw) retire_o = 1'b1;
          else      w_next   = ST_WB;
        end
      end
      ST_WB: begin
        reg_write_o  = !w_dest_zero;
        reg_dst_o    = w_rtype;
        mem_to_reg_o = w_lw;
        retire_o     = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
    // Skips and completions share the same PC advance and boundary decision.
    if (w_fault) retire_o = 1'b1;
    if (retire_o) begin
      pc_write_o = 1'b1;
      w_next     = run_i ? ST_FETCH : ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      instr_cnt_o <= '0;
      fault_cnt_o <= '0;
    end else begin
      r_state <= w_next;
      if (retire_o) instr_cnt_o <= instr_cnt_o + 1'b1;
      if (w_fault && (fault_cnt_o != {FAULT_W{1'b1}})) fault_cnt_o <= fault_cnt_o + 1'b1;
    end
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i, run_i, mem_ready_i, alu_zero_i, addr_misalign_i;
  logic [31:0] instr_i;
  logic        mem_req_o, mem_we_o, mem_sel_o, ir_write_o, pc_write_o, pc_src_o;
  logic [2:0]  alu_op_o, state_o;
  logic        alu_src_b_o, reg_write_o, reg_dst_o, mem_to_reg_o, retire_o;
  logic [31:0] instr_cnt_o;
  logic [15:0] fault_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  multicycle_ctrl #(.CNT_W(32), .FAULT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .instr_i(instr_i),
    .mem_ready_i(mem_ready_i), .alu_zero_i(alu_zero_i), .addr_misalign_i(addr_misalign_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .alu_op_o(alu_op_o), .alu_src_b_o(alu_src_b_o), .reg_write_o(reg_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .retire_o(retire_o),
    .state_o(state_o), .instr_cnt_o(instr_cnt_o), .fault_cnt_o(fault_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; run_i = 1'b0; instr_i = 32'h0; mem_ready_i = 1'b0;
    alu_zero_i = 1'b0; addr_misalign_i = 1'b0;
    cyc(); cyc();
    chk("rst_state", state_o, 0);
    chk("rst_icnt", instr_cnt_o, 0);
    chk("rst_fcnt", fault_cnt_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_retire", retire_o, 0);

    // Reset asserted while a fetch is outstanding
    rst_i = 1'b0; run_i = 1'b1; mem_ready_i = 1'b1; instr_i = 32'h00221820;
    cyc();
    chk("pre_fetch_state", state_o, 1);
    chk("pre_fetch_req", mem_req_o, 1);
    rst_i = 1'b1;
    #1;
    chk("async_req_drop", mem_req_o, 0);
    chk("async_state", state_o, 0);
    cyc();
    rst_i = 1'b0;
    #1;
    chk("post_rst_state", state_o, 0);
    chk("post_rst_icnt", instr_cnt_o, 0);
    cyc();

    // ADD r3,r1,r2: FETCH, DECODE, EXEC, WB
    chk("add_fetch_state", state_o, 1);
    chk("add_fetch_req", mem_req_o, 1);
    chk("add_fetch_sel", mem_sel_o, 0);
    chk("add_irw", ir_write_o, 1);
    cyc();
    chk("add_dec_state", state_o, 2);
    chk("add_dec_req", mem_req_o, 0);
    cyc();
    chk("add_exec_state", state_o, 3);
    chk("add_exec_aluop", alu_op_o, 0);
    chk("add_exec_srcb", alu_src_b_o, 0);
    chk("add_exec_retire", retire_o, 0);
    cyc();
    chk("add_wb_state", state_o, 5);
    chk("add_wb_regw", reg_write_o, 1);
    chk("add_wb_regdst", reg_dst_o, 1);
    chk("add_wb_aluop", alu_op_o, 0);
    chk("add_wb_retire", retire_o, 1);
    chk("add_wb_pcw", pc_write_o, 1);
    chk("add_wb_pcsrc", pc_src_o, 0);
    chk("add_wb_icnt", instr_cnt_o, 0);
    instr_i = 32'h8C050008;
    cyc();

    // LW r5,8(r0) with ready held off for three MEM cycles
    chk("lw_fetch_state", state_o, 1);
    chk("add_icnt", instr_cnt_o, 1);
    cyc();
    mem_ready_i = 1'b0;
    cyc();
    chk("lw_exec_srcb", alu_src_b_o, 1);
    chk("lw_exec_aluop", alu_op_o, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      mem_ready_i = (i == 3);
      chk("lw_mem_state", state_o, 4);
      chk("lw_mem_req", mem_req_o, 1);
      chk("lw_mem_sel", mem_sel_o, 1);
      chk("lw_mem_we", mem_we_o, 0);
      chk("lw_mem_retire", retire_o, 0);
    end
    cyc();
    chk("lw_wb_state", state_o, 5);
    chk("lw_wb_m2r", mem_to_reg_o, 1);
    chk("lw_wb_regw", reg_write_o, 1);
    chk("lw_wb_regdst", reg_dst_o, 0);
    chk("lw_wb_retire", retire_o, 1);
    instr_i = 32'h1021FFFE;
    cyc();

    // BEQ taken then not taken; retires from EXEC
    chk("lw_icnt", instr_cnt_o, 2);
    for (int k = 0; k < 2; k++) begin
      chk("beq_fetch_state", state_o, 1);
      cyc(); cyc();
      alu_zero_i = (k == 0);
      #1;
      chk("beq_exec_state", state_o, 3);
      chk("beq_exec_aluop", alu_op_o, 1);
      chk("beq_exec_pcw", pc_write_o, 1);
      chk("beq_exec_pcsrc", pc_src_o, (k == 0) ? 1 : 0);
      chk("beq_exec_retire", retire_o, 1);
      cyc();
      chk("beq_next_state", state_o, 1);
    end
    chk("beq_icnt", instr_cnt_o, 4);
    alu_zero_i = 1'b0;

    // Misaligned SW skips from EXEC
    instr_i = 32'hAC220001;
    cyc(); cyc();
    addr_misalign_i = 1'b1;
    #1;
    chk("swmis_exec_retire", retire_o, 1);
    chk("swmis_exec_req", mem_req_o, 0);
    chk("swmis_exec_pcw", pc_write_o, 1);
    chk("swmis_exec_pcsrc", pc_src_o, 0);
    cyc();
    addr_misalign_i = 1'b0;
    chk("swmis_next_state", state_o, 1);
    chk("swmis_fcnt", fault_cnt_o, 1);
    chk("swmis_icnt", instr_cnt_o, 5);

    // Illegal opcode 0x3F skips from DECODE
    instr_i = 32'hFC000000;
    cyc();
    chk("ill_dec_state", state_o, 2);
    chk("ill_dec_retire", retire_o, 1);
    chk("ill_dec_pcw", pc_write_o, 1);
    cyc();
    chk("ill_next_state", state_o, 1);
    chk("ill_fcnt", fault_cnt_o, 2);
    chk("ill_icnt", instr_cnt_o, 6);

    // ADDI r0,r0,5 with run dropped in EXEC
    instr_i = 32'h20000005;
    cyc(); cyc();
    run_i = 1'b0;
    chk("addi_exec_srcb", alu_src_b_o, 1);
    cyc();
    chk("addi_wb_state", state_o, 5);
    chk("addi_wb_regw", reg_write_o, 0);
    chk("addi_wb_retire", retire_o, 1);
    cyc();
    chk("addi_idle_state", state_o, 0);
    chk("addi_icnt", instr_cnt_o, 7);
    cyc(); cyc();
    chk("idle_hold_state", state_o, 0);
    chk("idle_hold_req", mem_req_o, 0);

    // Aligned SW: FETCH, DECODE, EXEC, MEM retire
    run_i = 1'b1; instr_i = 32'hAC220004; mem_ready_i = 1'b1;
    cyc(); cyc(); cyc();
    chk("sw_exec_state", state_o, 3);
    run_i = 1'b0;
    cyc();
    chk("sw_mem_state", state_o, 4);
    chk("sw_mem_we", mem_we_o, 1);
    chk("sw_mem_sel", mem_sel_o, 1);
    chk("sw_mem_retire", retire_o, 1);
    chk("sw_mem_pcw", pc_write_o, 1);
    cyc();
    chk("sw_idle_state", state_o, 0);
    chk("sw_icnt", instr_cnt_o, 8);
    chk("sw_fcnt", fault_cnt_o, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
